// File: rtl/tqvp_edge_counter_if.sv
// rtl/tqvp_edge_counter_if.sv - register bus between the SPI register bridge and the edge counter
// Signals:
//   address[3:0]  bridge -> peripheral  register address
//   data_write    bridge -> peripheral  one-cycle write strobe
//   data_in[7:0]  bridge -> peripheral  write data
//   data_out[7:0] peripheral -> bridge  combinational read data for address
interface tqvp_edge_counter_if;
  logic [3:0] address;
  logic       data_write;
  logic [7:0] data_in;
  logic [7:0] data_out;

  modport master (output address, output data_write, output data_in, input data_out);
  modport slave  (input address, input data_write, input data_in, output data_out);
endinterface

// File: rtl/tqvp_edge_counter.sv
// rtl/tqvp_edge_counter.sv - TinyQV peripheral counting edges on one selectable ui_in channel
// Ports:
//   clk          clock
//   rst          asynchronous active-high reset
//   ui_in[7:0]   input bus, already synchronized
//   uo_out[7:0]  registered status: [0] MATCH, [1] OVF, [2] EDGE, [7:3] zero
//   bus          register interface (slave side): address, data_write, data_in, data_out
// Registers: 0x0 CTRL, 0x1 CMD/STATUS, 0x4..0x7 SNAP, 0x8..0xB CMP (little-endian).
module tqvp_edge_counter #(
  parameter int COUNT_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         ui_in,
  output logic [7:0]         uo_out,
  tqvp_edge_counter_if.slave bus
);

  logic [5:0]         ctrl;  // [0] EN, [1] RISE, [2] FALL, [5:3] CH
  logic               prev;
  logic               edge_q;
  logic               ovf;
  logic               match;
  logic [COUNT_W-1:0] count;
  logic [COUNT_W-1:0] snap;
  logic [COUNT_W-1:0] cmp;

  logic [2:0]         ch;
  logic [2:0]         new_ch;
  logic               wr_ctrl;
  logic               wr_cmd;
  logic               wr_cmp;
  logic               ch_change;
  logic               cur;
  logic               rise;
  logic               fall;
  logic               counted;
  logic               clear;
  logic               take_snap;
  logic [COUNT_W-1:0] count_inc;
  logic [31:0]        snap32;
  logic [31:0]        cmp32;
  logic [31:0]        cmp_next32;

  assign ch        = ctrl[5:3];
  assign new_ch    = bus.data_in[5:3];
  assign wr_ctrl   = bus.data_write && (bus.address == 4'h0);
  assign wr_cmd    = bus.data_write && (bus.address == 4'h1);
  assign wr_cmp    = bus.data_write && (bus.address[3:2] == 2'b10);
  assign ch_change = wr_ctrl && (new_ch != ch);

  assign cur  = ui_in[ch];
  assign rise = !prev && cur;
  assign fall = prev && !cur;

  // A channel switch makes prev meaningless for this cycle, so nothing is counted.
  assign counted   = ctrl[0] && ((ctrl[1] && rise) || (ctrl[2] && fall)) && !ch_change;
  assign clear     = wr_cmd && bus.data_in[0];
  assign take_snap = wr_cmd && bus.data_in[1];
  assign count_inc = count + COUNT_W'(1);

  // Zero-extended views; bits at or above COUNT_W read 0 and are dropped on write.
  assign snap32 = 32'(snap);
  assign cmp32  = 32'(cmp);

  always_comb begin
    cmp_next32 = cmp32;
    case (bus.address[1:0])
      2'd0:    cmp_next32[7:0]   = bus.data_in;
      2'd1:    cmp_next32[15:8]  = bus.data_in;
      2'd2:    cmp_next32[23:16] = bus.data_in;
      default: cmp_next32[31:24] = bus.data_in;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl   <= '0;
      prev   <= 1'b0;
      edge_q <= 1'b0;
      ovf    <= 1'b0;
      match  <= 1'b0;
      count  <= '0;
      snap   <= '0;
      cmp    <= '0;
    end else begin
      prev   <= ch_change ? ui_in[new_ch] : cur;
      edge_q <= counted;
      if (wr_ctrl) ctrl <= bus.data_in[5:0];
      // Compare below sees the old cmp, so a same-cycle CMP write does not affect it.
      if (wr_cmp) cmp <= cmp_next32[COUNT_W-1:0];
      // Snapshot samples count before any clear or increment of this cycle.
      if (take_snap) snap <= count;
      if (clear) begin
        count <= '0;
        ovf   <= 1'b0;
        match <= 1'b0;
      end else if (counted) begin
        count <= count_inc;
        if (&count) ovf <= 1'b1;
        if (count_inc == cmp) match <= 1'b1;
      end
    end
  end

  assign uo_out = {5'b00000, edge_q, ovf, match};

  always_comb begin
    bus.data_out = 8'h00;
    case (bus.address)
      4'h0:    bus.data_out = {2'b00, ctrl};
      4'h1:    bus.data_out = {6'b000000, match, ovf};
      4'h4:    bus.data_out = snap32[7:0];
      4'h5:    bus.data_out = snap32[15:8];
      4'h6:    bus.data_out = snap32[23:16];
      4'h7:    bus.data_out = snap32[31:24];
      4'h8:    bus.data_out = cmp32[7:0];
      4'h9:    bus.data_out = cmp32[15:8];
      4'hA:    bus.data_out = cmp32[23:16];
      4'hB:    bus.data_out = cmp32[31:24];
      default: bus.data_out = 8'h00;
    endcase
  end

endmodule

// File: doc/tqvp_edge_counter.md
Name: tqvp_edge_counter

Overview:
- TinyQV peripheral that consumes the synchronized ui_in bus and the 4-bit address / 8-bit data register interface driven by the SPI register bridge.
- Counts rising and/or falling edges on one selectable ui_in channel into a wrapping counter.
- Provides a compare-match flag, a sticky overflow flag, a snapshot mechanism for coherent multi-byte reads, and status on uo_out.

Parameters:
- COUNT_W, 32, counter width in bits, legal range 8..32. Snapshot and compare bits at or above COUNT_W read as 0 and are ignored on write.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- ui_in  input  8  input bus, already 2-stage synchronized
- uo_out  output  8  status outputs
- address  input  4  register address
- data_write  input  1  one-cycle write strobe; data_in written to address
- data_in  input  8  write data
- data_out  output  8  read data for address, combinational mux of registers

Behaviour:
- Reset: one clock, asynchronous active-high reset; all registers clear to 0 while rst is high. This gives uo_out=0x00, count=0, snapshot=0, compare=0, flags=0, CTRL=0x00, prev=0.
- Register map (unlisted addresses read 0x00, writes ignored):
  - 0x0 CTRL (R/W): [0] EN, [1] RISE, [2] FALL, [5:3] CH, [7:6] read 0.
  - 0x1 CMD/STATUS: write bit0=CLEAR (count and both flags to 0), bit1=SNAP (copy count to snapshot); read [0]=OVF, [1]=MATCH, others 0.
  - 0x4..0x7 SNAP byte0..3 (RO, little-endian).
  - 0x8..0xB CMP byte0..3 (R/W, little-endian, byte-wise update).
- Edge detection:
  - prev <= ui_in[CH] every cycle.
  - Rising edge: prev=0 and ui_in[CH]=1. Falling edge: prev=1 and ui_in[CH]=0.
  - Edge is counted when EN=1 and the matching RISE/FALL bit is set.
- CH change: on a CTRL write that changes CH, prev loads ui_in[new CH] and no edge is counted that cycle.
- Latency: edge sampled in cycle k -> count+1 visible in cycle k+1, and uo_out[2] (EDGE) high for exactly cycle k+1.
- Arithmetic:
  - Count wraps modulo 2^COUNT_W.
  - On the wrap from all-ones to 0, OVF is set (sticky).
  - When the post-increment value equals CMP, MATCH is set (sticky).
  - Only increments trigger MATCH; writing CMP equal to the current count does not.
- uo_out: [0]=MATCH, [1]=OVF, [2]=EDGE, [7:3]=0, all registered.
- Simultaneous events:
  - CLEAR and a counted edge in the same cycle: CLEAR wins (count=0, flags 0, EDGE still pulses).
  - CLEAR and SNAP together: the snapshot takes the pre-clear count.
  - SNAP and a counted edge together: the snapshot takes the pre-increment count.
  - A CMP byte write and an increment in the same cycle: the compare uses the old CMP.
- EN=0: prev keeps tracking the input, count holds, no EDGE pulse.
- Reset asserted mid-count: all state is lost immediately, asynchronously. No edge is counted in the first cycle after deassert, because prev=0 and a high input is a rising edge only if RISE is set; CTRL=0 after reset guarantees no count.

Test Plan:
- Reset, then read all 16 addresses -> every data_out=0x00, uo_out=0x00.
- CTRL=0x03 (EN, RISE, CH0); apply 5 pulses on ui_in[0]; SNAP; read 0x4..0x7 -> 05 00 00 00. EDGE pulses 5 times, each 1 cycle wide, one cycle after the sampled rise.
- CTRL=0x07, CH=0; 3 full pulses -> count=6. Then CTRL=0x2F (CH=5) while ui_in[5]=1 and ui_in[0]=0 -> no spurious count; count stays 6.
- CMP=0x00000004, CTRL=0x03, 4 rising edges -> MATCH set on the 4th, uo_out[0]=1 one cycle after the 4th edge. 5th edge -> MATCH stays 1. CLEAR -> uo_out[0]=0, count=0.
- COUNT_W=8, count 255 edges, then 1 more -> count=0x00, OVF=1, uo_out[1]=1, STATUS read=0x01 (or 0x03 if CMP matched).
- Write CMD=0x03 in the same cycle as a counted edge with count=9 -> snapshot reads 9, count=0, flags 0. Assert rst mid-stream -> uo_out=0x00 asynchronously, before the next clk edge.
